// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RCV,
    STORE,
    EOPWAIT,
    BADSYNC,
    EIDLE
  } rcu_state_t;

  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

endpackage

// File: rtl/usb_rx_rcu.sv
// USB full-speed receiver control unit: sequences sync, payload stores and EOP.
// Optional RCU_OVERFLOW_ERR_EN: a byte arriving while the FIFO is full aborts the packet.
module usb_rx_rcu
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = USB_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       full,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error
);

  rcu_state_t state_q, state_d;
  logic       bits_pend_q, bits_pend_d;
  logic       rcving_q, rcving_d;
  logic       w_enable_q, w_enable_d;
  logic       r_error_q, r_error_d;
  logic       eop_bit;

  assign eop_bit = eop && shift_enable;

  always_comb begin
    state_d     = state_q;
    bits_pend_d = bits_pend_q;

    if (byte_received) begin
      bits_pend_d = 1'b0;
    end else if (shift_enable) begin
      bits_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (d_edge) state_d = SYNC;
      end
      SYNC: begin
        if (byte_received) begin
          state_d = (rcv_data == SYNC_BYTE) ? RCV : BADSYNC;
        end else if (eop_bit) begin
          state_d = EIDLE;
        end
      end
      RCV: begin
        if (byte_received) begin
`ifdef RCU_OVERFLOW_ERR_EN
          // Skipping STORE on overflow keeps w_enable a pure decode of the next state.
          state_d = full ? BADSYNC : STORE;
`else
          state_d = STORE;
`endif
        end else if (eop_bit) begin
          state_d = bits_pend_q ? EIDLE : EOPWAIT;
        end
      end
      STORE: begin
        state_d = RCV;
      end
      EOPWAIT: begin
        if (d_edge) state_d = IDLE;
      end
      BADSYNC: begin
        if (eop_bit) state_d = EIDLE;
      end
      EIDLE: begin
        if (d_edge) state_d = SYNC;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rcving_d   = state_d inside {SYNC, RCV, STORE, EOPWAIT, BADSYNC};
    w_enable_d = (state_d == STORE);
    r_error_d  = (state_d == EIDLE);
  end

`ifndef RCU_OVERFLOW_ERR_EN
  // Overflow is handled by the FIFO's own drop policy in this build.
  logic unused_full;
  assign unused_full = full;
`endif

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q     <= IDLE;
      bits_pend_q <= 1'b0;
      rcving_q    <= 1'b0;
      w_enable_q  <= 1'b0;
      r_error_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_pend_q <= bits_pend_d;
      rcving_q    <= rcving_d;
      w_enable_q  <= w_enable_d;
      r_error_q   <= r_error_d;
    end
  end

  assign rcving   = rcving_q;
  assign w_enable = w_enable_q;
  assign r_error  = r_error_q;

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Directed self-checking bench for usb_rx_rcu.
module tb_usb_rx_rcu;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       full;
  logic       rcving;
  logic       w_enable;
  logic       r_error;

  int         errors = 0;
  int         checks = 0;
  int         wcnt   = 0;
  logic [7:0] wdata  = 8'h00;
  int         w0;

`ifdef RCU_OVERFLOW_ERR_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  usb_rx_rcu #(.SYNC_BYTE(8'h80)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .eop          (eop),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .rcv_data     (rcv_data),
    .full         (full),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_enable) begin
      wcnt  <= wcnt + 1;
      wdata <= rcv_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; pulses are dropped afterwards, eop is held.
  task automatic cyc(input logic de, input logic e, input logic se, input logic br);
    d_edge        = de;
    eop           = e;
    shift_enable  = se;
    byte_received = br;
    @(posedge clk);
    #1;
    d_edge        = 1'b0;
    shift_enable  = 1'b0;
    byte_received = 1'b0;
  endtask

  task automatic shifts(input int n, input logic e);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, e, 1'b1, 1'b0);
      cyc(1'b0, e, 1'b0, 1'b0);
      cyc(1'b0, e, 1'b0, 1'b0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rcv_data = b;
    shifts(8, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b0;
  endtask

  initial begin
    n_rst = 1'b1; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
    byte_received = 1'b0; rcv_data = 8'h00; full = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_rcving", rcving, 0);
    chk("rst_wen", w_enable, 0);
    chk("rst_rerr", r_error, 0);
    n_rst = 1'b0;

    // 1: good packet
    w0 = wcnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_rcving_on", rcving, 1);
    send_byte(8'h80);
    chk("t1_no_wen_sync", w_enable, 0);
    send_byte(8'hA5);
    chk("t1_wen", w_enable, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_wen_pulse", w_enable, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t1_eopwait_rcving", rcving, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_rcving_off", rcving, 0);
    chk("t1_rerr", r_error, 0);
    chk("t1_wcnt", wcnt - w0, 1);
    chk("t1_wdata", wdata, 8'hA5);

    // 2: bad sync
    w0 = wcnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h81);
    chk("t2_no_wen", w_enable, 0);
    chk("t2_rerr_pre", r_error, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t2_rerr", r_error, 1);
    chk("t2_rcving", rcving, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_rerr_held", r_error, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_rerr_clr", r_error, 0);
    chk("t2_rcving_new", rcving, 1);
    chk("t2_wcnt", wcnt - w0, 0);
    do_reset();

    // 3: short byte
    w0 = wcnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h80);
    send_byte(8'h3C);
    shifts(3, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_rerr", r_error, 1);
    chk("t3_rcving", rcving, 0);
    chk("t3_wcnt", wcnt - w0, 1);
    chk("t3_wdata", wdata, 8'h3C);
    do_reset();

    // 4: byte_received and eop together
    w0 = wcnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h80);
    rcv_data = 8'h5A;
    shifts(8, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t4_wen", w_enable, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_wen_off", w_enable, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_rerr", r_error, 0);
    chk("t4_eopwait_rcving", rcving, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_rcving_off", rcving, 0);
    chk("t4_wcnt", wcnt - w0, 1);
    chk("t4_wdata", wdata, 8'h5A);

    // 5: reset mid-packet
    w0 = wcnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h80);
    rcv_data = 8'h0F;
    shifts(4, 1'b0);
    do_reset();
    chk("t5_rcving", rcving, 0);
    chk("t5_wen", w_enable, 0);
    chk("t5_rerr", r_error, 0);
    chk("t5_wcnt_abort", wcnt - w0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h80);
    send_byte(8'hC3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_good_wcnt", wcnt - w0, 1);
    chk("t5_good_wdata", wdata, 8'hC3);
    chk("t5_good_rerr", r_error, 0);
    chk("t5_good_rcving", rcving, 0);

    // 6: FIFO full at second data byte
    w0 = wcnt;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h80);
    send_byte(8'h11);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    full = 1'b1;
    send_byte(8'h22);
    chk("t6_wen_full", w_enable, OVF ? 0 : 1);
    full = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_rerr", r_error, OVF ? 1 : 0);
    chk("t6_wcnt", wcnt - w0, OVF ? 1 : 2);
    chk("t6_wdata", wdata, OVF ? 8'h11 : 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
